pipeline_interlock: RTL and testbench

Central hazard and interlock controller for the 5-stage MIPS pipeline. It sits beside the EX-stage forwarding muxes and handles the hazards forwarding cannot resolve:

- load-use (bubble insertion),
- multi-cycle MUL/DIV occupancy of EX (counted stall),
- memory not-ready (full freeze),
- taken branches resolved in EX (wrong-path flush).

It drives write-enable and flush for the PC and every pipeline register, and keeps a stall-cycle counter.

---
 rtl/pipeline_pkg.sv | 6 +
 rtl/load_use_detect.sv | 14 +
 rtl/pipeline_interlock.sv | 97 +++++++++
 tb/tb_pipeline_interlock.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared state enum, zero-register id and stall counter width for the pipeline interlock
package pipeline_pkg;
  typedef enum logic {RUN = 1'b0, MULDIV = 1'b1} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int STALL_W = 32;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use compare between the EX load destination and the ID sources
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       if_id_uses_rt,
  output logic       hazard
);
  assign hazard = id_ex_mem_read && id_ex_rt != REG_ZERO &&
                  (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt));
endmodule

// File: rtl/pipeline_interlock.sv
// pipeline_interlock: PC/pipeline-register write and flush control for load-use, MUL/DIV (MULDIV_INTERLOCK_EN), mem freeze and branch flush
module pipeline_interlock
  import pipeline_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         if_id_rs,
  input  logic [4:0]         if_id_rt,
  input  logic               if_id_uses_rt,
  input  logic [4:0]         id_ex_rt,
  input  logic               id_ex_mem_read,
  input  logic               branch_taken,
  input  logic               muldiv_start,
  input  logic               mem_stall,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic               id_ex_write,
  output logic               id_ex_flush,
  output logic               ex_mem_write,
  output logic               ex_mem_flush,
  output logic               mem_wb_write,
  output logic               muldiv_busy,
  output logic               muldiv_done,
  output logic [STALL_W-1:0] stall_cycles
);
  logic lu, md_stall, lus, br;
  load_use_detect u_lud (
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs),
    .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt),
    .hazard(lu)
  );
`ifdef MULDIV_INTERLOCK_EN
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic md_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    md_stall = 1'b0;
    md_done = 1'b0;
    if (state == MULDIV) begin
      md_stall = cnt > 4'd1;
      md_done = cnt == 4'd1;
      if (!mem_stall) begin
        cnt_n = cnt - 4'd1;
        state_n = cnt == 4'd1 ? RUN : MULDIV;
      end
    end else if (muldiv_start && !branch_taken) begin
      md_stall = 1'b1;
      if (!mem_stall) begin
        cnt_n = 4'(MULDIV_LAT - 1);
        state_n = MULDIV;
      end
    end
  end
  assign muldiv_busy = state == MULDIV;
  assign muldiv_done = md_done && !mem_stall;
`else
  localparam int unused_lat = MULDIV_LAT;
  logic unused_muldiv;
  assign unused_muldiv = muldiv_start;
  assign md_stall = 1'b0;
  assign muldiv_busy = 1'b0;
  assign muldiv_done = 1'b0;
`endif
  always_comb begin
    br = !mem_stall && !md_stall && branch_taken;
    lus = !mem_stall && !md_stall && !branch_taken && lu;
    pc_write = !(mem_stall || md_stall || lus);
    if_id_write = !(mem_stall || md_stall || lus);
    id_ex_write = !(mem_stall || md_stall);
    ex_mem_write = !mem_stall;
    mem_wb_write = !mem_stall;
    if_id_flush = br;
    id_ex_flush = br || lus;
    ex_mem_flush = !mem_stall && md_stall;
  end
  always_ff @(posedge clk) begin
    if (rst) stall_cycles <= '0;
    else if (!pc_write) stall_cycles <= stall_cycles + 1'b1;
  end
endmodule

// File: tb/tb_pipeline_interlock.sv
// tb_pipeline_interlock: directed and scattered vectors against a cycle-level hazard model
module tb_pipeline_interlock;
  localparam int L = 4;
`ifdef MULDIV_INTERLOCK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] if_id_rs = '0, if_id_rt = '0, id_ex_rt = '0;
  logic if_id_uses_rt = 1'b0, id_ex_mem_read = 1'b0, branch_taken = 1'b0;
  logic muldiv_start = 1'b0, mem_stall = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic ex_mem_write, ex_mem_flush, mem_wb_write, muldiv_busy, muldiv_done;
  logic [31:0] stall_cycles;
  int vectors = 0, miscompares = 0;
  bit started = 1'b0;
  bit m_busy = 1'b0;
  int m_left = 0;
  logic [31:0] m_stalls = '0;

  pipeline_interlock #(.MULDIV_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_rt(id_ex_rt), .id_ex_mem_read(id_ex_mem_read),
    .branch_taken(branch_taken), .muldiv_start(muldiv_start), .mem_stall(mem_stall),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
    .mem_wb_write(mem_wb_write), .muldiv_busy(muldiv_busy),
    .muldiv_done(muldiv_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      bit lu, mds, mdd, ep, lus, br;
      logic [9:0] exp_v, got_v;
      lu = id_ex_mem_read && id_ex_rt != 0 &&
           (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt));
      mds = 1'b0;
      mdd = 1'b0;
      if (EN && m_busy) begin
        mds = m_left > 0;
        mdd = m_left == 0 && !mem_stall;
      end else if (EN && muldiv_start && !branch_taken) mds = 1'b1;
      br = !mem_stall && !mds && branch_taken;
      lus = !mem_stall && !mds && !branch_taken && lu;
      ep = !(mem_stall || mds || lus);
      exp_v = {ep, ep, br, !(mem_stall || mds), br || lus, !mem_stall,
               !mem_stall && mds, !mem_stall, EN && m_busy, mdd};
      got_v = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, ex_mem_flush, mem_wb_write, muldiv_busy, muldiv_done};
      chk("ctrl", {22'd0, got_v}, {22'd0, exp_v});
      chk("stall_cycles", stall_cycles, m_stalls);
      if (rst) begin
        m_busy = 1'b0;
        m_left = 0;
        m_stalls = '0;
      end else begin
        if (!mem_stall) begin
          if (EN && m_busy) begin
            if (m_left == 0) m_busy = 1'b0;
            else m_left--;
          end else if (EN && muldiv_start && !branch_taken) begin
            m_busy = 1'b1;
            m_left = L - 2;
          end
        end
        if (!ep) m_stalls++;
      end
    end
  end

  task automatic set(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic [4:0] exrt, input logic mr, input logic br,
                     input logic mst, input logic ms);
    if_id_rs = rs;
    if_id_rt = rt;
    if_id_uses_rt = urt;
    id_ex_rt = exrt;
    id_ex_mem_read = mr;
    branch_taken = br;
    muldiv_start = mst;
    mem_stall = ms;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    started = 1'b1;
    tick();
    idle();
    chk("reset_pc_write", {31'd0, pc_write}, 32'd1);
    chk("reset_busy", {31'd0, muldiv_busy}, 32'd0);
    tick();
    rst = 1'b0;
    idle(); tick();
    set(8, 0, 0, 8, 1, 0, 0, 0);
    chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
    chk("lu_if_id_write", {31'd0, if_id_write}, 32'd0);
    chk("lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    chk("lu_stall_before", stall_cycles, 32'd0);
    tick();
    idle();
    chk("lu_stall_after", stall_cycles, 32'd1);
    tick();
    set(0, 0, 0, 0, 1, 0, 0, 0);
    chk("zero_reg_pc_write", {31'd0, pc_write}, 32'd1);
    tick();
    set(3, 9, 0, 9, 1, 0, 0, 0);
    chk("rt_unused_pc_write", {31'd0, pc_write}, 32'd1);
    tick();
    set(3, 9, 1, 9, 1, 0, 0, 0);
    chk("rt_used_pc_write", {31'd0, pc_write}, 32'd0);
    tick();
    set(8, 0, 0, 8, 1, 1, 0, 0);
    chk("br_if_id_flush", {31'd0, if_id_flush}, 32'd1);
    chk("br_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    chk("br_pc_write", {31'd0, pc_write}, 32'd1);
    tick();
    idle();
    chk("stall_before_md", stall_cycles, 32'd2);
    tick();
    set(0, 0, 0, 0, 0, 0, 1, 0);
    chk("md_start_pc_write", {31'd0, pc_write}, {31'd0, !EN});
    chk("md_start_ex_mem_flush", {31'd0, ex_mem_flush}, {31'd0, EN});
    tick();
    idle();
    chk("md_busy", {31'd0, muldiv_busy}, {31'd0, EN});
    tick();
    idle(); tick();
    idle();
    chk("md_done", {31'd0, muldiv_done}, {31'd0, EN});
    chk("md_done_pc_write", {31'd0, pc_write}, 32'd1);
    tick();
    idle();
    chk("md_run_busy", {31'd0, muldiv_busy}, 32'd0);
    chk("md_stall_total", stall_cycles, EN ? 32'd5 : 32'd2);
    tick();
    set(0, 0, 0, 0, 0, 0, 1, 0); tick();
    idle(); tick();
    for (int i = 0; i < 2; i++) begin
      set(0, 0, 0, 0, 0, 0, 0, 1);
      chk("frz_writes", {27'd0, pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, 32'd0);
      chk("frz_done", {31'd0, muldiv_done}, 32'd0);
      tick();
    end
    idle();
    chk("frz_after_pc_write", {31'd0, pc_write}, {31'd0, !EN});
    tick();
    idle();
    chk("frz_done_late", {31'd0, muldiv_done}, {31'd0, EN});
    tick();
    idle();
    chk("frz_stall_total", stall_cycles, EN ? 32'd10 : 32'd4);
    tick();
    set(0, 0, 0, 0, 0, 0, 1, 0); tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("rst_mid_busy", {31'd0, muldiv_busy}, 32'd0);
    chk("rst_mid_stall", stall_cycles, 32'd0);
    chk("rst_mid_pc_write", {31'd0, pc_write}, 32'd1);
    tick();
    for (int i = 0; i < 300; i++) begin
      set(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      tick();
    end
    idle(); tick();
    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
